// File: rtl/pipelined_decode.sv
// Decode stage: register file with write-through reads, load-use stall detection,
// two-word (immediate) instruction assembly, and the D/E pipeline register.
module pipelined_decode #(
   parameter int W  = 16,
   parameter int N  = 3,
   parameter int CW = 13
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [W-1:0]  instr,
   input  logic [CW-1:0] ctrl_in,
   input  logic          ctrl_imm,
   input  logic          ctrl_memread,
   input  logic          flush,
   input  logic          wb_en,
   input  logic [N-1:0]  wb_addr,
   input  logic [W-1:0]  wb_data,
   output logic          stall_out,
   output logic          de_valid,
   output logic [CW-1:0] de_ctrl,
   output logic          de_memread,
   output logic [W-1:0]  de_rsrc,
   output logic [W-1:0]  de_rdst,
   output logic [N-1:0]  de_src_addr,
   output logic [N-1:0]  de_dst_addr,
   output logic [3:0]    de_shamt,
   output logic [W-1:0]  de_imm
);

   localparam int NR = 1 << N;

   if (W < 10 + 2*N) begin : g_width_check
      $error("pipelined_decode: W must be at least 10+2N");
   end

   typedef enum logic {S_INSTR, S_IMM} state_t;

   typedef struct packed {
      logic          valid;
      logic [CW-1:0] ctrl;
      logic          memread;
      logic [W-1:0]  rsrc;
      logic [W-1:0]  rdst;
      logic [N-1:0]  src_addr;
      logic [N-1:0]  dst_addr;
      logic [3:0]    shamt;
      logic [W-1:0]  imm;
   } de_t;

   typedef struct packed {
      logic [CW-1:0] ctrl;
      logic          memread;
      logic [N-1:0]  src;
      logic [N-1:0]  dst;
      logic [3:0]    shamt;
   } hold_t;

   state_t       r_state;
   de_t          r_de;
   hold_t        r_hold;
   logic [W-1:0] r_rf [NR];

   logic [N-1:0] w_src, w_dst, w_rd_src, w_rd_dst;
   logic [W-1:0] w_rsrc, w_rdst;
   logic         w_hazard;
   logic         w_unused;

   assign w_src    = instr[W-7 -: N];
   assign w_dst    = instr[W-7-N -: N];
   assign w_unused = ^instr;

   // The immediate word carries no addresses; operands come from the held first word.
   assign w_rd_src = (r_state == S_IMM) ? r_hold.src : w_src;
   assign w_rd_dst = (r_state == S_IMM) ? r_hold.dst : w_dst;
   assign w_rsrc   = (wb_en && wb_addr == w_rd_src) ? wb_data : r_rf[w_rd_src];
   assign w_rdst   = (wb_en && wb_addr == w_rd_dst) ? wb_data : r_rf[w_rd_dst];

   assign w_hazard  = (r_state == S_INSTR) && in_valid && r_de.valid && r_de.memread &&
                      ((r_de.dst_addr == w_src) || (r_de.dst_addr == w_dst));
   assign stall_out = w_hazard && !flush && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_INSTR;
         r_de    <= '0;
         r_hold  <= '0;
         for (int i = 0; i < NR; i++) r_rf[i] <= '0;
      end else begin
         if (wb_en) r_rf[wb_addr] <= wb_data;
         r_de <= '0;
         if (flush) begin
            r_state <= S_INSTR;
            r_hold  <= '0;
         end else if (w_hazard || !in_valid) begin
            r_state <= r_state;
         end else if (r_state == S_INSTR) begin
            if (ctrl_imm) begin
               r_hold.ctrl    <= ctrl_in;
               r_hold.memread <= ctrl_memread;
               r_hold.src     <= w_src;
               r_hold.dst     <= w_dst;
               r_hold.shamt   <= instr[3:0];
               r_state        <= S_IMM;
            end else begin
               r_de.valid    <= 1'b1;
               r_de.ctrl     <= ctrl_in;
               r_de.memread  <= ctrl_memread;
               r_de.rsrc     <= w_rsrc;
               r_de.rdst     <= w_rdst;
               r_de.src_addr <= w_src;
               r_de.dst_addr <= w_dst;
               r_de.shamt    <= instr[3:0];
            end
         end else begin
            r_de.valid    <= 1'b1;
            r_de.ctrl     <= r_hold.ctrl;
            r_de.memread  <= r_hold.memread;
            r_de.rsrc     <= w_rsrc;
            r_de.rdst     <= w_rdst;
            r_de.src_addr <= r_hold.src;
            r_de.dst_addr <= r_hold.dst;
            r_de.shamt    <= r_hold.shamt;
            r_de.imm      <= instr;
            r_state       <= S_INSTR;
         end
      end
   end

   assign de_valid    = r_de.valid;
   assign de_ctrl     = r_de.ctrl;
   assign de_memread  = r_de.memread;
   assign de_rsrc     = r_de.rsrc;
   assign de_rdst     = r_de.rdst;
   assign de_src_addr = r_de.src_addr;
   assign de_dst_addr = r_de.dst_addr;
   assign de_shamt    = r_de.shamt;
   assign de_imm      = r_de.imm;

endmodule

// File: doc/pipelined_decode.md
PIPELINED_DECODE -- requirements
Module: pipelined_decode

Interface
REQ-001 Parameter W, default 16, data/instruction width.
REQ-002 Parameter N, default 3, register address width; register file holds 2^N registers.
REQ-003 Parameter CW, default 13, control bundle width (MEM 4 + EX 6 + WB 3).
REQ-004 Constraint: W >= 10+2N; elaboration SHALL fail otherwise.
REQ-005 clk  in  1  single clock, all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  F/D word valid.
REQ-008 instr  in  W  F/D word; opcode=instr[W-1:W-6], src=next N bits, dst=next N bits, shamt=instr[3:0].
REQ-009 ctrl_in  in  CW  control bundle decoded from current opcode by the control unit.
REQ-010 ctrl_imm  in  1  current opcode is two-word (immediate word follows).
REQ-011 ctrl_memread  in  1  current opcode is a load.
REQ-012 flush  in  1  branch/exception flush from later stage.
REQ-013 wb_en  in  1; wb_addr  in  N; wb_data  in  W  write-back port.
REQ-014 stall_out  out  1  hold F/D this cycle.
REQ-015 de_valid  out  1; de_ctrl  out  CW; de_memread  out  1.
REQ-016 de_rsrc, de_rdst  out  W  operand values; de_src_addr, de_dst_addr  out  N.
REQ-017 de_shamt  out  4; de_imm  out  W.

Function
REQ-018 All de_* outputs SHALL be registered (D/E pipeline register); stall_out SHALL be combinational.
REQ-019 Register file SHALL write wb_data to wb_addr on the rising edge when wb_en=1; all addresses writable.
REQ-020 Reads SHALL be combinational with write-through: if wb_en=1 and wb_addr equals read address, read returns wb_data.
REQ-021 FSM states: S_INSTR, S_IMM; S_INSTR after reset.
REQ-022 Hazard = state S_INSTR, in_valid=1, de_valid=1, de_memread=1, and de_dst_addr equals decoded src or dst.
REQ-023 Priority per cycle: flush > hazard > in_valid=0 > normal operation.
REQ-024 Flush: next edge de_valid=0, all de_* zero, state S_INSTR, held word discarded; stall_out=0.
REQ-025 Hazard: stall_out=1; next edge D/E loads a bubble (all de_* zero), state unchanged.
REQ-026 in_valid=0 (no flush): D/E loads a bubble; state and held word unchanged.
REQ-027 S_INSTR, in_valid=1, ctrl_imm=0: D/E loads de_valid=1, ctrl_in, ctrl_memread, register reads, addresses, shamt, de_imm=0.
REQ-028 S_INSTR, in_valid=1, ctrl_imm=1: hold ctrl_in, ctrl_memread, src, dst, shamt; D/E loads bubble; go S_IMM.
REQ-029 S_IMM, in_valid=1: D/E loads held fields, de_imm=instr, de_valid=1; operands read from held addresses in this cycle; go S_INSTR.
REQ-030 Hazard check SHALL NOT apply to the immediate word.
REQ-031 Latency: single-word instruction appears on de_* one edge after acceptance; two-word instruction one edge after its immediate word.
REQ-032 Register write and D/E update SHALL both occur in a flush or hazard cycle.

Reset
REQ-033 rst=1 SHALL immediately force all registers to 0, all de_* to 0, state S_INSTR, held word cleared; stall_out=0 while rst=1.
REQ-034 Reset asserted in S_IMM SHALL discard the pending two-word instruction.

Verification
REQ-035 Reset, then write R3=0x1234 via WB, decode instr src=3 dst=3 -> next edge de_rsrc=de_rdst=0x1234, de_valid=1.
REQ-036 Same-cycle wb_en to R5=0xBEEF while decoding src=5 -> de_rsrc=0xBEEF (write-through).
REQ-037 Load with dst=2 accepted, next word uses src=2 -> stall_out=1 for one cycle, bubble in D/E, then instruction issues with de_valid=1.
REQ-038 Two-word instr (ctrl_imm=1) then word 0x00FF -> one bubble, then de_imm=0x00FF with held ctrl/addresses, de_valid=1.
REQ-039 flush asserted while in S_IMM -> next edge de_valid=0, state S_INSTR; following word decoded as an instruction, not an immediate.
REQ-040 rst asserted mid-stream asynchronously -> de_* and all registers read 0 without a clock edge.
